// File: rtl/hba_arbiter.sv
// ----------------------------------------------------------------------------
// hba_arbiter
//   Round-robin arbiter that lets NUM_MASTERS HBA bus masters share one slave
//   bus. A master requests with mreq, is granted with a registered one-hot
//   mgrant, and then drives its transfer (mselect/mrnw/mabus/mdbus) straight
//   through to the shared slave bus. A stalled transfer is terminated by a
//   synthetic acknowledge after TIMEOUT_CYCLES and recorded in a sticky error.
//
// Handshake:
//   mreq[i] high asks for the bus; mgrant[i] answers one edge later and stays
//   high while mreq[i] or mselect[i] is high. Each cycle with mselect[i] high
//   under grant is one transfer beat offered to the slave; the beat completes
//   in the cycle mxferack[i] is high (slave ack, or synthetic ack on timeout).
//   Dropping both mreq[i] and mselect[i] releases the bus at the next edge,
//   and every handover passes through one IDLE turnaround cycle.
//
// Ports:
//   hba_clk, hba_reset           clock, asynchronous active-high reset
//   mreq/mrnw/mselect            per-master request, direction, transfer strobe
//   mabus/mdbus                  per-master address/write data (slice i)
//   mgrant/mxferack              per-master grant (registered) and acknowledge
//   mdbus_slave                  read data returned to the masters
//   hba_rnw/hba_select           shared slave bus controls
//   hba_abus/hba_dbus            shared slave address and write data
//   hba_xferack/hba_dbus_slave   OR of slave acknowledges / read data
//   bus_error/error_master       sticky timeout flag and offending master
//   error_clear                  clears bus_error on the next edge
//   o_dbg_owned                  FSM state (1 = OWNED) for observation
// ----------------------------------------------------------------------------
module hba_arbiter #(
    parameter int NUM_MASTERS    = 4,
    parameter int DBUS_WIDTH     = 8,
    parameter int ADDR_WIDTH     = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                              hba_clk,
    input  logic                              hba_reset,
    input  logic [NUM_MASTERS-1:0]            mreq,
    input  logic [NUM_MASTERS-1:0]            mrnw,
    input  logic [NUM_MASTERS-1:0]            mselect,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] mabus,
    input  logic [NUM_MASTERS*DBUS_WIDTH-1:0] mdbus,
    output logic [NUM_MASTERS-1:0]            mgrant,
    output logic [NUM_MASTERS-1:0]            mxferack,
    output logic [DBUS_WIDTH-1:0]             mdbus_slave,
    output logic                              hba_rnw,
    output logic                              hba_select,
    output logic [ADDR_WIDTH-1:0]             hba_abus,
    output logic [DBUS_WIDTH-1:0]             hba_dbus,
    input  logic                              hba_xferack,
    input  logic [DBUS_WIDTH-1:0]             hba_dbus_slave,
    output logic                              bus_error,
    output logic [2:0]                        error_master,
    input  logic                              error_clear,
    output logic                              o_dbg_owned
);

    localparam int IDX_W = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } state_t;

    state_t                 r_state, w_state_nxt;
    logic [IDX_W-1:0]       r_owner, w_owner_nxt;
    logic [IDX_W-1:0]       r_last_owner, w_last_owner_nxt;
    logic [IDX_W-1:0]       w_pick;
    logic                   w_found;
    logic [NUM_MASTERS-1:0] r_mgrant, w_mgrant_nxt;
    logic [7:0]             r_cnt, w_cnt_nxt;
    logic                   r_bus_error;
    logic [2:0]             r_error_master;
    logic                   w_synth_ack;

    logic [ADDR_WIDTH-1:0]  w_abus_arr [NUM_MASTERS];
    logic [DBUS_WIDTH-1:0]  w_dbus_arr [NUM_MASTERS];

    // Unpack the flat per-master buses so the owner can select by index.
    for (genvar g = 0; g < NUM_MASTERS; g++) begin : g_unpack
        assign w_abus_arr[g] = mabus[g*ADDR_WIDTH +: ADDR_WIDTH];
        assign w_dbus_arr[g] = mdbus[g*DBUS_WIDTH +: DBUS_WIDTH];
    end

    // Round-robin search starting just after the previous owner, so the
    // last owner is considered last.
    always_comb begin
        w_found = 1'b0;
        w_pick  = r_last_owner;
        for (int i = 1; i <= NUM_MASTERS; i++) begin
            if (!w_found && mreq[IDX_W'((int'(r_last_owner) + i) % NUM_MASTERS)]) begin
                w_found = 1'b1;
                w_pick  = IDX_W'((int'(r_last_owner) + i) % NUM_MASTERS);
            end
        end
    end

    // Synthetic ack fires once the stall counter has reached the limit and the
    // beat is still outstanding; a real ack in that cycle takes precedence.
    assign w_synth_ack = (r_state == ST_OWNED) && mselect[r_owner] && !hba_xferack &&
                         (r_cnt == 8'(TIMEOUT_CYCLES));

    always_comb begin
        w_state_nxt      = r_state;
        w_owner_nxt      = r_owner;
        w_last_owner_nxt = r_last_owner;
        w_mgrant_nxt     = r_mgrant;
        w_cnt_nxt        = '0;
        hba_select       = 1'b0;
        hba_rnw          = 1'b0;
        hba_abus         = '0;
        hba_dbus         = '0;
        mxferack         = '0;
        case (r_state)
            ST_IDLE: begin
                w_mgrant_nxt = '0;
                if (w_found) begin
                    w_state_nxt          = ST_OWNED;
                    w_owner_nxt          = w_pick;
                    w_mgrant_nxt[w_pick] = 1'b1;
                end
            end
            ST_OWNED: begin
                hba_select         = mselect[r_owner];
                hba_rnw            = mrnw[r_owner];
                hba_abus           = w_abus_arr[r_owner];
                hba_dbus           = w_dbus_arr[r_owner];
                mxferack[r_owner]  = (mselect[r_owner] & hba_xferack) | w_synth_ack;
                if (mselect[r_owner] && !hba_xferack && !w_synth_ack) begin
                    w_cnt_nxt = r_cnt + 8'd1;
                end
                // A master still mid-beat keeps the bus even after dropping mreq.
                if (!mreq[r_owner] && !mselect[r_owner]) begin
                    w_state_nxt      = ST_IDLE;
                    w_mgrant_nxt     = '0;
                    w_last_owner_nxt = r_owner;
                end
            end
            default: begin
                w_state_nxt  = ST_IDLE;
                w_mgrant_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge hba_clk or posedge hba_reset) begin
        if (hba_reset) begin
            r_state        <= ST_IDLE;
            r_owner        <= '0;
            r_last_owner   <= IDX_W'(NUM_MASTERS - 1);
            r_mgrant       <= '0;
            r_cnt          <= '0;
            r_bus_error    <= 1'b0;
            r_error_master <= '0;
        end else begin
            r_state      <= w_state_nxt;
            r_owner      <= w_owner_nxt;
            r_last_owner <= w_last_owner_nxt;
            r_mgrant     <= w_mgrant_nxt;
            r_cnt        <= w_cnt_nxt;
            // A timeout in the same cycle as error_clear keeps the flag set.
            if (w_synth_ack) begin
                r_bus_error    <= 1'b1;
                r_error_master <= 3'(r_owner);
            end else if (error_clear) begin
                r_bus_error <= 1'b0;
            end
        end
    end

    assign mgrant       = r_mgrant;
    assign mdbus_slave  = w_synth_ack ? '0 : hba_dbus_slave;
    assign bus_error    = r_bus_error;
    assign error_master = r_error_master;
    assign o_dbg_owned  = (r_state == ST_OWNED);

endmodule

// File: doc/hba_arbiter.md
HBA_ARBITER -- requirements
Module: hba_arbiter

Interface
REQ-001 Parameter NUM_MASTERS, default 4: number of HBA bus masters sharing one slave bus (2..8).
REQ-002 Parameter DBUS_WIDTH, default 8: data bus width.
REQ-003 Parameter ADDR_WIDTH, default 12: address bus width.
REQ-004 Parameter TIMEOUT_CYCLES, default 255: consecutive unacknowledged select cycles before a synthetic acknowledge (1..255).
REQ-005 hba_clk  input  1  single clock for all logic.
REQ-006 hba_reset  input  1  asynchronous, active-high reset.
REQ-007 mreq  input  NUM_MASTERS  bus request, one bit per master.
REQ-008 mrnw  input  NUM_MASTERS  per-master read-not-write.
REQ-009 mselect  input  NUM_MASTERS  per-master transfer in progress.
REQ-010 mabus  input  NUM_MASTERS*ADDR_WIDTH  per-master address; master i uses slice i.
REQ-011 mdbus  input  NUM_MASTERS*DBUS_WIDTH  per-master write data; master i uses slice i.
REQ-012 mgrant  output  NUM_MASTERS  one-hot-or-zero bus grant, registered.
REQ-013 mxferack  output  NUM_MASTERS  per-master transfer acknowledge.
REQ-014 mdbus_slave  output  DBUS_WIDTH  read data returned to masters.
REQ-015 hba_rnw, hba_select  output  1 each  shared slave bus controls.
REQ-016 hba_abus  output  ADDR_WIDTH; hba_dbus  output  DBUS_WIDTH  shared slave address and write data.
REQ-017 hba_xferack  input  1  OR of all slave acknowledges.
REQ-018 hba_dbus_slave  input  DBUS_WIDTH  OR of all slave read data.
REQ-019 bus_error  output  1  sticky timeout flag; error_master  output  3  index of the master that timed out.
REQ-020 error_clear  input  1  clears bus_error on the next edge.

Function
REQ-021 FSM states SHALL be IDLE and OWNED; owner index and last_owner SHALL be registers.
REQ-022 In IDLE with any mreq bit high, the block SHALL grant the first requester searching round-robin from last_owner+1 (wrap modulo NUM_MASTERS), registering mgrant and entering OWNED on the next edge (1-cycle latency).
REQ-023 In IDLE, all bus outputs (hba_select, hba_rnw, hba_abus, hba_dbus) and mgrant SHALL be 0.
REQ-024 In OWNED, hba_rnw/hba_select/hba_abus/hba_dbus SHALL combinationally equal the owner's mrnw/mselect/mabus/mdbus slices.
REQ-025 In OWNED, mxferack[owner] SHALL equal hba_select & hba_xferack, OR the synthetic ack; all other mxferack bits SHALL be 0.
REQ-026 mdbus_slave SHALL equal hba_dbus_slave, except 0 during a synthetic ack cycle.
REQ-027 Release: when mreq[owner]=0 and mselect[owner]=0, the next edge SHALL clear mgrant, set last_owner=owner, enter IDLE; mreq dropped while mselect high SHALL NOT release the grant.
REQ-028 Ownership handover SHALL always pass through one IDLE cycle (bus turnaround); a master SHALL keep the grant for back-to-back transfers while mreq stays high.
REQ-029 Timeout counter (8 bits) SHALL increment each OWNED cycle with hba_select=1 and hba_xferack=0, and clear otherwise.
REQ-030 When the counter reaches TIMEOUT_CYCLES, the next cycle SHALL issue a one-cycle synthetic ack to the owner, clear the counter, set bus_error=1 and load error_master=owner.
REQ-031 bus_error SHALL remain set until error_clear; a timeout in the same cycle as error_clear SHALL win (bus_error stays 1, error_master updated).
REQ-032 A real hba_xferack arriving in the same cycle the synthetic ack would fire SHALL be treated as a normal ack (no error).

Reset
REQ-033 hba_reset high SHALL immediately, without a clock edge, force state=IDLE, mgrant=0, counter=0, bus_error=0, error_master=0, last_owner=NUM_MASTERS-1 (master 0 has first priority).
REQ-034 Reset asserted mid-transfer SHALL drop hba_select and all mxferack combinationally; no transfer completes.

Verification
REQ-035 After reset, mreq=0001 -> mgrant=0001 one edge later; master 0 writes abus=0x123 dbus=0xA5 -> same values on hba_abus/hba_dbus; hba_xferack=1 -> mxferack=0001 same cycle.
REQ-036 mreq=1111 held, each owner doing one transfer then dropping mreq -> grant order 0,1,2,3,0 with exactly one IDLE cycle between grants.
REQ-037 TIMEOUT_CYCLES=8, master 2 owns, select high, no slave ack -> synthetic mxferack=0100 on cycle 9, mdbus_slave=0x00, bus_error=1, error_master=2.
REQ-038 error_clear pulsed in the same cycle as a second timeout -> bus_error remains 1; error_clear alone later -> bus_error=0 next edge.
REQ-039 Master 1 drops mreq while mselect high -> mgrant=0010 held until mselect low, then IDLE next edge.
REQ-040 Async reset asserted mid-transfer between clock edges -> mgrant=0 and hba_select=0 before next edge; after release, mreq=1111 -> master 0 granted first.
